// File: rtl/fpro_bus_arbiter.sv
// Two-master FPro MMIO bus arbiter: IDLE -> ISSUE (one-cycle strobe) -> ACK (one-cycle ack pulse).
// Latency: request sampled at N, bus strobe at N+1, ack at N+2, next arbitration at N+3.
// Backpressure: masters hold their request until ack; define FPRO_ARB_RR_EN for round-robin ties (default m0 wins ties).
module fpro_bus_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_cs,
    input  logic              m0_wr,
    input  logic              m0_rd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_ack,
    input  logic              m1_cs,
    input  logic              m1_wr,
    input  logic              m1_rd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_ack,
    output logic              fp_mmio_cs,
    output logic              fp_wr,
    output logic              fp_rd,
    output logic [ADDR_W-1:0] fp_addr,
    output logic [DATA_W-1:0] fp_wr_data,
    input  logic [DATA_W-1:0] fp_rd_data,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                is_wr_q, is_wr_d;
    logic                req0, req1;
    logic                pick_m1;

    assign req0 = m0_cs & (m0_wr | m0_rd);
    assign req1 = m1_cs & (m1_wr | m1_rd);

`ifdef FPRO_ARB_RR_EN
    // last_grant_q = 1 means m1 won most recently; a tie goes to the other master.
    logic last_grant_q, last_grant_d;

    assign pick_m1 = req1 & (~req0 | ~last_grant_q);

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (req0 | req1)) begin
            last_grant_d = pick_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign pick_m1 = req1 & ~req0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        rdata_d   = rdata_q;
        is_wr_d   = is_wr_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    state_d   = ISSUE;
                    grant_d   = {pick_m1, ~pick_m1};
                    addr_d    = pick_m1 ? m1_addr : m0_addr;
                    wr_data_d = pick_m1 ? m1_wr_data : m0_wr_data;
                    // wr and rd both set resolves to a write
                    is_wr_d   = pick_m1 ? m1_wr : m0_wr;
                end
            end
            ISSUE: begin
                if (!is_wr_q) begin
                    rdata_d = fp_rd_data;
                end
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            addr_q    <= '0;
            wr_data_q <= '0;
            rdata_q   <= '0;
            is_wr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            rdata_q   <= rdata_d;
            is_wr_q   <= is_wr_d;
        end
    end

    assign fp_mmio_cs = (state_q == ISSUE);
    assign fp_wr      = (state_q == ISSUE) &  is_wr_q;
    assign fp_rd      = (state_q == ISSUE) & ~is_wr_q;
    assign fp_addr    = addr_q;
    assign fp_wr_data = wr_data_q;
    assign m0_rd_data = rdata_q;
    assign m1_rd_data = rdata_q;
    assign m0_ack     = (state_q == ACK) & grant_q[0];
    assign m1_ack     = (state_q == ACK) & grant_q[1];
    assign grant      = grant_q;

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Bench for fpro_bus_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_fpro_bus_arbiter;
    localparam int AW = 21;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_cs = 1'b0, m0_wr = 1'b0, m0_rd = 1'b0;
    logic          m1_cs = 1'b0, m1_wr = 1'b0, m1_rd = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wr_data = '0, m1_wr_data = '0;
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic          m0_ack, m1_ack;
    logic          fp_mmio_cs, fp_wr, fp_rd;
    logic [AW-1:0] fp_addr;
    logic [DW-1:0] fp_wr_data;
    logic [DW-1:0] fp_rd_data = '0;
    logic [1:0]    grant;
    logic [6:0]    obs_vec;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    fpro_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_cs(m0_cs), .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_addr(m0_addr),
        .m0_wr_data(m0_wr_data), .m0_rd_data(m0_rd_data), .m0_ack(m0_ack),
        .m1_cs(m1_cs), .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_addr(m1_addr),
        .m1_wr_data(m1_wr_data), .m1_rd_data(m1_rd_data), .m1_ack(m1_ack),
        .fp_mmio_cs(fp_mmio_cs), .fp_wr(fp_wr), .fp_rd(fp_rd), .fp_addr(fp_addr),
        .fp_wr_data(fp_wr_data), .fp_rd_data(fp_rd_data), .grant(grant)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {cs, wr, rd, grant[1:0], m0_ack, m1_ack}
    assign obs_vec = {fp_mmio_cs, fp_wr, fp_rd, grant, m0_ack, m1_ack};

    task automatic clear_masters();
        m0_cs = 1'b0; m0_wr = 1'b0; m0_rd = 1'b0; m0_addr = '0; m0_wr_data = '0;
        m1_cs = 1'b0; m1_wr = 1'b0; m1_rd = 1'b0; m1_addr = '0; m1_wr_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_masters();
        fp_rd_data = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        checks++; if (obs_vec !== 7'b0) begin errors++; $display("FAIL reset_strobes: got %b expected %b", obs_vec, 7'b0); end
        checks++; if ({fp_addr, fp_wr_data} !== '0) begin errors++; $display("FAIL reset_bus: got %h/%h expected 0/0", fp_addr, fp_wr_data); end
        checks++; if ({m0_rd_data, m1_rd_data} !== '0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", m0_rd_data, m1_rd_data); end
        m0_cs = 1'b1; m0_rd = 1'b1;
        @(negedge clk);
        checks++; if (obs_vec !== 7'b0) begin errors++; $display("FAIL reset_blocks_req: got %b expected %b", obs_vec, 7'b0); end
        clear_masters();
        fp_rd_data = '0;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (obs_vec !== 7'b0) begin errors++; $display("FAIL idle_after_reset: got %b expected %b", obs_vec, 7'b0); end
    endtask

    task automatic test_read();
        m0_cs = 1'b1; m0_rd = 1'b1; m0_wr = 1'b0; m0_addr = 21'h00010;
        @(negedge clk);
        checks++; if (obs_vec !== 7'b101_01_00) begin errors++; $display("FAIL read_issue: got %b expected %b", obs_vec, 7'b1010100); end
        checks++; if (fp_addr !== 21'h00010) begin errors++; $display("FAIL read_addr: got %h expected %h", fp_addr, 21'h00010); end
        fp_rd_data = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (obs_vec !== 7'b000_01_10) begin errors++; $display("FAIL read_ack: got %b expected %b", obs_vec, 7'b0000110); end
        checks++; if ({m0_rd_data, m1_rd_data} !== {2{32'hDEADBEEF}}) begin errors++; $display("FAIL read_data: got %h/%h expected deadbeef", m0_rd_data, m1_rd_data); end
        clear_masters();
        fp_rd_data = 32'h0;
        @(negedge clk);
        checks++; if (obs_vec !== 7'b0) begin errors++; $display("FAIL read_idle: got %b expected %b", obs_vec, 7'b0); end
        checks++; if (fp_addr !== 21'h00010) begin errors++; $display("FAIL read_addr_hold: got %h expected %h", fp_addr, 21'h00010); end
    endtask

    task automatic test_write();
        m1_cs = 1'b1; m1_wr = 1'b1; m1_addr = 21'h00204; m1_wr_data = 32'h12345678;
        @(negedge clk);
        checks++; if (obs_vec !== 7'b110_10_00) begin errors++; $display("FAIL write_issue: got %b expected %b", obs_vec, 7'b1101000); end
        checks++; if ({fp_addr, fp_wr_data} !== {21'h00204, 32'h12345678}) begin errors++; $display("FAIL write_bus: got %h/%h expected 00204/12345678", fp_addr, fp_wr_data); end
        fp_rd_data = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (obs_vec !== 7'b000_10_01) begin errors++; $display("FAIL write_ack: got %b expected %b", obs_vec, 7'b0001001); end
        checks++; if (m1_rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL write_keeps_rdata: got %h expected deadbeef", m1_rd_data); end
        clear_masters();
        @(negedge clk);
        checks++; if (obs_vec !== 7'b0 || fp_wr_data !== 32'h12345678) begin errors++; $display("FAIL write_idle: got %b/%h expected 0/12345678", obs_vec, fp_wr_data); end
    endtask

    task automatic test_wr_rd_both();
        int n_rd = 0;
        int n_wr = 0;
        m0_cs = 1'b1; m0_wr = 1'b1; m0_rd = 1'b1; m0_addr = 21'h00030; m0_wr_data = 32'h0000A5A5;
        fp_rd_data = 32'h11111111;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_rd += int'(fp_rd);
            n_wr += int'(fp_wr);
        end
        clear_masters();
        @(negedge clk);
        checks++; if (n_wr != 1 || n_rd != 0) begin errors++; $display("FAIL wr_rd_both: got wr=%0d rd=%0d expected wr=1 rd=0", n_wr, n_rd); end
        checks++; if (m0_rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_rdata: got %h expected deadbeef", m0_rd_data); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] g_q[$];
        int         t_q[$];
        logic [1:0] exp_g;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m0_cs = 1'b1; m0_rd = 1'b1; m0_addr = 21'h00100;
        m1_cs = 1'b1; m1_wr = 1'b1; m1_addr = 21'h00200; m1_wr_data = 32'h77;
        for (int i = 0; i < 20 && g_q.size() < 4; i++) begin
            @(negedge clk);
            if (fp_mmio_cs) begin
                g_q.push_back(grant);
                t_q.push_back(cyc);
            end
        end
        checks++; if (g_q.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", g_q.size()); end
        foreach (g_q[k]) begin
`ifdef FPRO_ARB_RR_EN
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            checks++; if (g_q[k] !== exp_g) begin errors++; $display("FAIL b2b_grant%0d: got %b expected %b", k, g_q[k], exp_g); end
            if (k > 0) begin
                checks++; if (t_q[k] - t_q[k-1] != 3) begin errors++; $display("FAIL b2b_period%0d: got %0d expected 3", k, t_q[k] - t_q[k-1]); end
            end
        end
        clear_masters();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        m1_cs = 1'b1; m1_rd = 1'b1; m1_addr = 21'h00044;
        @(negedge clk);
        checks++; if (obs_vec !== 7'b101_10_00) begin errors++; $display("FAIL mid_issue: got %b expected %b", obs_vec, 7'b1011000); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (obs_vec !== 7'b0) begin errors++; $display("FAIL mid_abort: got %b expected %b", obs_vec, 7'b0); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (obs_vec !== 7'b101_10_00) begin errors++; $display("FAIL mid_reissue: got %b expected %b", obs_vec, 7'b1011000); end
        fp_rd_data = 32'h55AA55AA;
        @(negedge clk);
        checks++; if (obs_vec !== 7'b000_10_01 || m1_rd_data !== 32'h55AA55AA) begin errors++; $display("FAIL mid_complete: got %b/%h expected 0001001/55aa55aa", obs_vec, m1_rd_data); end
        clear_masters();
        @(negedge clk);
    endtask

    task automatic test_random();
        // transaction-level model: phase 0 idle, 1 on bus, 2 acknowledging
        int            ph, own, win;
        bit            mw;
        logic [AW-1:0] ma;
        logic [DW-1:0] mwd, mrd, rdn;
        bit            pend[2];
        logic          cs[2], wr[2], rd[2];
        logic [AW-1:0] ad[2];
        logic [DW-1:0] dt[2];
        logic [1:0]    cmd;
        logic [1:0]    eg;
        logic [6:0]    exp_vec;
        bit            rq0, rq1, rst;
`ifdef FPRO_ARB_RR_EN
        bit            last;
        last = 1'b1;
`endif
        reset = 1'b1;
        clear_masters();
        @(negedge clk);
        reset = 1'b0;
        ph = 0; own = 0; mw = 1'b0; ma = '0; mwd = '0; mrd = '0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; cs[i] = 1'b0; wr[i] = 1'b0; rd[i] = 1'b0; ad[i] = '0; dt[i] = '0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && ph == 2 && own == i) pend[i] = 1'b0;
                if (!pend[i]) begin
                    ad[i] = AW'($urandom);
                    dt[i] = $urandom;
                    if ($urandom_range(0, 2) != 0) begin
                        pend[i] = 1'b1;
                        cmd = 2'($urandom_range(1, 3));
                        cs[i] = 1'b1; wr[i] = cmd[0]; rd[i] = cmd[1];
                    end else begin
                        cs[i] = 1'($urandom_range(0, 1));
                        wr[i] = cs[i] ? 1'b0 : 1'($urandom_range(0, 1));
                        rd[i] = cs[i] ? 1'b0 : 1'($urandom_range(0, 1));
                    end
                end
            end
            rst = ($urandom_range(0, 49) == 0);
            rdn = $urandom;
            m0_cs = cs[0]; m0_wr = wr[0]; m0_rd = rd[0]; m0_addr = ad[0]; m0_wr_data = dt[0];
            m1_cs = cs[1]; m1_wr = wr[1]; m1_rd = rd[1]; m1_addr = ad[1]; m1_wr_data = dt[1];
            reset = rst;
            fp_rd_data = rdn;
            rq0 = cs[0] & (wr[0] | rd[0]);
            rq1 = cs[1] & (wr[1] | rd[1]);
            if (rst) begin
                ph = 0; own = 0; mw = 1'b0; ma = '0; mwd = '0; mrd = '0;
`ifdef FPRO_ARB_RR_EN
                last = 1'b1;
`endif
            end else if (ph == 0) begin
                if (rq0 || rq1) begin
                    if (rq0 && rq1) begin
`ifdef FPRO_ARB_RR_EN
                        win = last ? 0 : 1;
`else
                        win = 0;
`endif
                    end else begin
                        win = rq1 ? 1 : 0;
                    end
                    own = win; ma = ad[win]; mwd = dt[win]; mw = wr[win]; ph = 1;
`ifdef FPRO_ARB_RR_EN
                    last = (win == 1);
`endif
                end
            end else if (ph == 1) begin
                if (!mw) mrd = rdn;
                ph = 2;
            end else begin
                ph = 0;
            end
            @(negedge clk);
            eg = (ph == 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
            exp_vec = {ph == 1, ph == 1 && mw, ph == 1 && !mw, eg, ph == 2 && own == 0, ph == 2 && own == 1};
            checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL rand_ctrl c%0d: got %b expected %b", c, obs_vec, exp_vec); end
            checks++; if ({fp_addr, fp_wr_data} !== {ma, mwd}) begin errors++; $display("FAIL rand_bus c%0d: got %h/%h expected %h/%h", c, fp_addr, fp_wr_data, ma, mwd); end
            checks++; if ({m0_rd_data, m1_rd_data} !== {mrd, mrd}) begin errors++; $display("FAIL rand_rdata c%0d: got %h/%h expected %h", c, m0_rd_data, m1_rd_data, mrd); end
        end
        reset = 1'b0;
        clear_masters();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_wr_rd_both();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpro_bus_arbiter.md
FPRO_BUS_ARBITER -- requirements
Module: fpro_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 21, FPro MMIO address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, FPro data width.
REQ-003 The block SHALL have port clk, input, 1, single system clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports m0_cs / m1_cs, input, 1 each, requester select.
REQ-006 The block SHALL have ports m0_wr, m0_rd / m1_wr, m1_rd, input, 1 each, requester write and read command.
REQ-007 The block SHALL have ports m0_addr / m1_addr, input, ADDR_W, requester address.
REQ-008 The block SHALL have ports m0_wr_data / m1_wr_data, input, DATA_W, requester write data.
REQ-009 The block SHALL have ports m0_rd_data / m1_rd_data, output, DATA_W, returned read data.
REQ-010 The block SHALL have ports m0_ack / m1_ack, output, 1 each, one-cycle transaction-complete pulse.
REQ-011 The block SHALL have ports fp_mmio_cs, fp_wr, fp_rd, output, 1 each, shared FPro bus strobes.
REQ-012 The block SHALL have ports fp_addr (output, ADDR_W), fp_wr_data (output, DATA_W) and fp_rd_data (input, DATA_W), shared FPro bus.
REQ-013 The block SHALL have port grant, output, 2, one-hot owner of the current transaction; 00 when IDLE.

Function
REQ-014 A request from master x SHALL be defined as mx_cs & (mx_wr | mx_rd); the master SHALL hold it stable until mx_ack.
REQ-015 The FSM SHALL have states IDLE, ISSUE and ACK.
REQ-016 In IDLE with at least one request, the FSM SHALL select a winner, latch its addr, wr_data and command into registers, set grant, and go to ISSUE; with no request it SHALL stay in IDLE.
REQ-017 In ISSUE, the block SHALL assert fp_mmio_cs and exactly one of fp_wr/fp_rd for exactly one cycle, then go to ACK.
REQ-018 If a request has both wr and rd set, the block SHALL perform a write only.
REQ-019 On a read, fp_rd_data SHALL be captured at the end of the ISSUE cycle into a shared rdata register driving both m0_rd_data and m1_rd_data; writes SHALL leave rdata unchanged.
REQ-020 In ACK, the block SHALL pulse the granted master's ack for one cycle, never the other master's, then return to IDLE.
REQ-021 Latency: a request sampled in IDLE at cycle N SHALL give the bus strobe at N+1, ack at N+2, and earliest next arbitration at N+3.
REQ-022 fp_addr and fp_wr_data SHALL hold the last latched values outside ISSUE; fp_mmio_cs, fp_wr and fp_rd SHALL be 0 outside ISSUE.
REQ-023 A register last_grant SHALL record the most recent winner; when both masters request in IDLE, the winner SHALL be the master that is not last_grant.
REQ-024 With one requester, that master SHALL win regardless of last_grant.
REQ-025 New or changed requests arriving during ISSUE/ACK SHALL be ignored until IDLE.

Reset
REQ-026 Reset SHALL force: state IDLE, grant 00, all fp strobes 0, fp_addr 0, fp_wr_data 0, rdata 0, both acks 0, and last_grant = m1, so m0 wins the first tie.
REQ-027 Reset asserted mid-transaction SHALL abort it with no ack and no further bus strobe; the aborted request SHALL be re-arbitrated only if still presented after reset releases.

Configuration
REQ-028 Macro FPRO_ARB_RR_EN: when defined, ties SHALL be resolved round-robin per REQ-023.
REQ-029 When FPRO_ARB_RR_EN is undefined, ties SHALL always go to m0 (fixed priority); last_grant MAY be omitted; all other behaviour SHALL be identical.

Verification
REQ-030 m0 read only, addr 0x00010, fp_rd_data=0xDEADBEEF -> fp_rd strobe 1 cycle at N+1, m0_ack at N+2, m0_rd_data=0xDEADBEEF, m1_ack stays 0.
REQ-031 m1 write addr 0x00204, data 0x12345678 -> fp_wr=1, fp_addr=0x00204, fp_wr_data=0x12345678 for one cycle; m1_ack at N+2; rdata unchanged.
REQ-032 Both masters request continuously after reset, RR enabled -> grants m0,m1,m0,m1; one transaction per 3 cycles; without macro -> m0 every time.
REQ-033 m0 request with wr=rd=1 -> single fp_wr strobe, no fp_rd.
REQ-034 Reset asserted during ISSUE -> next cycle all strobes 0, grant 00, no ack; after release, held request completes normally.
